// File: rtl/lcd_video_pkg.sv
// lcd_video_pkg: shared constants, panel column map and scale clamp for the LCD video generator
package lcd_video_pkg;
  localparam int LCD_MAX_COLS = 40;
  localparam int LCD_MAX_ROWS = 16;
  localparam logic [7:0] LCD_BANK_OFFSET = 8'h50;
  function automatic logic [4:0] clamp_size(input logic [4:0] v, input logic [4:0] m);
    return (v == 5'd0) ? 5'd1 : (v > m) ? m : v;
  endfunction
  function automatic logic [5:0] col_map(input logic [5:0] c);
    return (c >= 6'(LCD_MAX_COLS)) ? 6'd0 :
           (c < 6'd8)  ? c :
           (c < 6'd16) ? c + 6'd1 :
           (c < 6'd24) ? 6'd52 - c :
           (c < 6'd32) ? 6'd51 - c :
           (c == 6'd32) ? 6'd8 :
           (c < 6'd36) ? c - 6'd16 :
           (c == 6'd36) ? 6'd28 : c;
  endfunction
endpackage

// File: rtl/lcd_window_scaler.sv
// lcd_window_scaler: per-frame scale latch, centred window offsets and LCD pixel stepping
module lcd_window_scaler
  import lcd_video_pkg::*;
#(
  parameter logic [9:0] WIDTH          = 10'd360,
  parameter logic [9:0] HEIGHT         = 10'd360,
  parameter logic [5:0] LCD_COLS       = 6'd32,
  parameter logic [4:0] LCD_ROWS       = 5'd16,
  parameter logic [4:0] MAX_PIXEL_SIZE = 5'd11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cfg_pixel_size_i,
  input  logic       cfg_grid_en_i,
  input  logic       vsync_i,
  input  logic       de_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic [4:0] pixel_size_o,
  output logic       lcd_active_o,
  output logic       lcd_grid_o,
  output logic [5:0] lcd_x_o,
  output logic [4:0] lcd_y_o,
  output logic [5:0] lcd_x_d_o,
  output logic [4:0] lcd_y_d_o
);
  logic [4:0] ps_q, ps_d, ps_m1, sx_q, sx_d, sy_q, sy_d, ly_q, ly_d;
  logic [5:0] lx_q, lx_d;
  logic [9:0] wx_q, wx_d, wy_q, wy_d, ox_q, ox_d, oy_q, oy_d;
  logic act_q, act_d, grid_q, grid_d, sx_wrap, sy_wrap, step_y;
  // x_i/y_i/de_i describe the position being registered, so outputs stay aligned with the raster
  always_comb begin
    ps_d = (reset || vsync_i) ? clamp_size(cfg_pixel_size_i, MAX_PIXEL_SIZE) : ps_q;
    wx_d = {4'd0, LCD_COLS} * {5'd0, ps_d};
    wy_d = {5'd0, LCD_ROWS} * {5'd0, ps_d};
    ox_d = (wx_d > WIDTH) ? 10'd0 : (WIDTH - wx_d) >> 1;
    oy_d = (wy_d > HEIGHT) ? 10'd0 : (HEIGHT - wy_d) >> 1;
    act_d = de_i && x_i >= ox_q && x_i < ox_q + wx_q && y_i >= oy_q && y_i < oy_q + wy_q;
    ps_m1 = ps_q - 5'd1;
    sx_wrap = sx_q == ps_m1;
    sy_wrap = sy_q == ps_m1;
    step_y = act_q && !act_d;
    sx_d = vsync_i ? 5'd0 : !act_q ? sx_q : sx_wrap ? 5'd0 : sx_q + 5'd1;
    lx_d = vsync_i ? 6'd0 : !(act_q && sx_wrap) ? lx_q : (lx_q == LCD_COLS - 6'd1) ? 6'd0 : lx_q + 6'd1;
    sy_d = vsync_i ? 5'd0 : !step_y ? sy_q : sy_wrap ? 5'd0 : sy_q + 5'd1;
    ly_d = vsync_i ? 5'd0 : !(step_y && sy_wrap) ? ly_q : (ly_q == LCD_ROWS - 5'd1) ? 5'd0 : ly_q + 5'd1;
    grid_d = cfg_grid_en_i && ps_q >= 5'd3 && act_d && (sx_d == ps_m1 || sy_d == ps_m1);
  end
  always_ff @(posedge clk) begin
    ps_q <= ps_d;
    wx_q <= wx_d;
    wy_q <= wy_d;
    ox_q <= ox_d;
    oy_q <= oy_d;
    if (reset) begin
      {sx_q, sy_q, lx_q, ly_q} <= '0;
      act_q <= 1'b0;
      grid_q <= 1'b0;
    end else begin
      {sx_q, sy_q, lx_q, ly_q} <= {sx_d, sy_d, lx_d, ly_d};
      act_q <= act_d;
      grid_q <= grid_d;
    end
  end
  assign pixel_size_o = ps_q;
  assign lcd_active_o = act_q;
  assign lcd_grid_o = grid_q;
  assign lcd_x_o = lx_q;
  assign lcd_y_o = ly_q;
  assign lcd_x_d_o = lx_d;
  assign lcd_y_d_o = ly_d;
endmodule

// File: rtl/lcd_scaled_video_gen.sv
// lcd_scaled_video_gen: raster timing plus scaled LCD segment grid mapping and RAM addressing
module lcd_scaled_video_gen
  import lcd_video_pkg::*;
#(
  parameter logic [9:0] WIDTH          = 10'd360,
  parameter logic [9:0] HEIGHT         = 10'd360,
  parameter logic [9:0] HBLANK_LEN     = 10'd84,
  parameter logic [9:0] VBLANK_LEN     = 10'd132,
  parameter logic [9:0] HSYNC_OFFSET   = 10'd5,
  parameter logic [9:0] VSYNC_OFFSET   = 10'd5,
  parameter logic [5:0] LCD_COLS       = 6'd32,
  parameter logic [4:0] LCD_ROWS       = 5'd16,
  parameter logic [4:0] MAX_PIXEL_SIZE = 5'd11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] cfg_pixel_size,
  input  logic       cfg_grid_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       lcd_active,
  output logic       lcd_grid,
  output logic [5:0] lcd_x,
  output logic [4:0] lcd_y,
  output logic [1:0] lcd_segment_row,
  output logic [7:0] video_addr,
  output logic [4:0] pixel_size
);
  localparam logic [9:0] H_LAST = WIDTH + HBLANK_LEN - 10'd1;
  localparam logic [9:0] V_LAST = HEIGHT + VBLANK_LEN - 10'd1;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [7:0] addr_q, addr_d;
  logic [5:0] lx_n;
  logic [4:0] ly_n;
  // every registered output is computed from the next position so all of them describe x_q/y_q
  always_comb begin
    x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
    y_d = (x_q != H_LAST) ? y_q : (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    hs_d = x_d == WIDTH + HSYNC_OFFSET;
    vs_d = y_d == HEIGHT + VSYNC_OFFSET && x_d == WIDTH + 10'd1;
    de_d = x_d < WIDTH && y_d < HEIGHT;
    addr_d = {1'b0, col_map(lx_n), ly_n[2]} + ((ly_n >= 5'(LCD_MAX_ROWS / 2)) ? LCD_BANK_OFFSET : 8'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= 10'd0;
      y_q <= 10'd0;
      {hs_q, vs_q, de_q} <= 3'd0;
      addr_q <= 8'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      {hs_q, vs_q, de_q} <= {hs_d, vs_d, de_d};
      addr_q <= addr_d;
    end
  end
  lcd_window_scaler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .LCD_COLS(LCD_COLS), .LCD_ROWS(LCD_ROWS),
    .MAX_PIXEL_SIZE(MAX_PIXEL_SIZE)
  ) u_scaler (
    .clk(clk), .reset(reset), .cfg_pixel_size_i(cfg_pixel_size), .cfg_grid_en_i(cfg_grid_en),
    .vsync_i(vs_q), .de_i(de_d), .x_i(x_d), .y_i(y_d), .pixel_size_o(pixel_size),
    .lcd_active_o(lcd_active), .lcd_grid_o(lcd_grid), .lcd_x_o(lcd_x), .lcd_y_o(lcd_y),
    .lcd_x_d_o(lx_n), .lcd_y_d_o(ly_n)
  );
  assign x = x_q;
  assign y = y_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de = de_q;
  assign video_addr = addr_q;
  assign lcd_segment_row = lcd_y[1:0];
endmodule

// File: tb/tb_lcd_scaled_video_gen.sv
// tb_lcd_scaled_video_gen: directed checks on a reduced 128x52 raster with a 40x16 LCD grid
module tb_lcd_scaled_video_gen;
  logic clk = 1'b0, reset = 1'b1, cfg_grid_en = 1'b0;
  logic [4:0] cfg_pixel_size = 5'd3;
  logic [9:0] x, y;
  logic hsync, vsync, de, lcd_active, lcd_grid;
  logic [5:0] lcd_x;
  logic [4:0] lcd_y, pixel_size;
  logic [1:0] lcd_segment_row;
  logic [7:0] video_addr;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  lcd_scaled_video_gen #(
    .WIDTH(10'd128), .HEIGHT(10'd52), .HBLANK_LEN(10'd12), .VBLANK_LEN(10'd6),
    .HSYNC_OFFSET(10'd3), .VSYNC_OFFSET(10'd2), .LCD_COLS(6'd40), .LCD_ROWS(5'd16),
    .MAX_PIXEL_SIZE(5'd3)
  ) dut (
    .clk(clk), .reset(reset), .cfg_pixel_size(cfg_pixel_size), .cfg_grid_en(cfg_grid_en),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de), .lcd_active(lcd_active),
    .lcd_grid(lcd_grid), .lcd_x(lcd_x), .lcd_y(lcd_y), .lcd_segment_row(lcd_segment_row),
    .video_addr(video_addr), .pixel_size(pixel_size)
  );
  task automatic goto(input int xt, input int yt);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(x == 10'(xt) && y == 10'(yt)) && n < 20000);
    if (!(x == 10'(xt) && y == 10'(yt))) begin
      vectors++; miscompares++;
      $display("FAIL goto(%0d,%0d): position not reached in 20000 cycles, at x=%0d y=%0d", xt, yt, x, y);
    end
  endtask
  task automatic wait_vsync(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (vsync !== 1'b1 && n < 20000);
    if (vsync !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL wait_vsync: no vsync within 20000 cycles");
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; cfg_pixel_size = 5'd3; cfg_grid_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({x, y} !== 20'd0) begin miscompares++; $display("FAIL reset_xy: got x=%0d y=%0d, expected 0 0", x, y); end
    vectors++;
    if ({hsync, vsync, de, lcd_active, lcd_grid} !== 5'd0) begin
      miscompares++; $display("FAIL reset_flags: got hs/vs/de/act/grid=%b, expected 00000", {hsync, vsync, de, lcd_active, lcd_grid});
    end
    vectors++;
    if ({lcd_x, lcd_y, video_addr} !== 19'd0) begin
      miscompares++; $display("FAIL reset_lcd: got lx=%0d ly=%0d addr=%h, expected 0 0 00", lcd_x, lcd_y, video_addr);
    end
    vectors++;
    if (pixel_size !== 5'd3) begin miscompares++; $display("FAIL reset_size: got %0d, expected 3", pixel_size); end
    reset = 1'b0;
  endtask
  task automatic test_timing;
    int n, de_n = 0, hs_n = 0, hs_bad = 0, act_n = 0;
    wait_vsync(n);
    vectors++;
    if (n !== 7689) begin miscompares++; $display("FAIL first_vsync_delay: got %0d cycles, expected 7689", n); end
    vectors++;
    if ({x, y} !== {10'd129, 10'd54}) begin miscompares++; $display("FAIL vsync_pos: got x=%0d y=%0d, expected 129 54", x, y); end
    n = 0;
    do begin
      @(negedge clk); n++;
      de_n += int'(de); act_n += int'(lcd_active);
      if (hsync) begin hs_n++; if (x != 10'd131) hs_bad++; end
    end while (vsync !== 1'b1 && n < 20000);
    vectors++;
    if (n !== 8120) begin miscompares++; $display("FAIL frame_len: got %0d cycles, expected 8120", n); end
    vectors++;
    if (de_n !== 6656) begin miscompares++; $display("FAIL de_count: got %0d, expected 6656", de_n); end
    vectors++;
    if (hs_n !== 58 || hs_bad !== 0) begin miscompares++; $display("FAIL hsync: got %0d pulses (%0d off x=131), expected 58 (0)", hs_n, hs_bad); end
    vectors++;
    if (act_n !== 5760) begin miscompares++; $display("FAIL active_count_s3: got %0d, expected 5760", act_n); end
  endtask
  task automatic test_grid;
    cfg_grid_en = 1'b1;
    goto(4, 2); vectors++;
    if ({lcd_active, lcd_grid} !== 2'b10) begin miscompares++; $display("FAIL grid_origin: got act/grid=%b, expected 10", {lcd_active, lcd_grid}); end
    goto(6, 2); vectors++;
    if (lcd_grid !== 1'b1) begin miscompares++; $display("FAIL grid_col_gap: got %b, expected 1", lcd_grid); end
    goto(5, 3); vectors++;
    if (lcd_grid !== 1'b0) begin miscompares++; $display("FAIL grid_inner: got %b, expected 0", lcd_grid); end
    goto(5, 4); vectors++;
    if (lcd_grid !== 1'b1) begin miscompares++; $display("FAIL grid_row_gap: got %b, expected 1", lcd_grid); end
    cfg_grid_en = 1'b0;
    goto(6, 5); vectors++;
    if (lcd_grid !== 1'b0) begin miscompares++; $display("FAIL grid_disabled: got %b, expected 0", lcd_grid); end
  endtask
  task automatic test_addr_map;
    goto(28, 14); vectors++;
    if ({lcd_x, lcd_y, video_addr} !== {6'd8, 5'd4, 8'h13}) begin
      miscompares++; $display("FAIL addr_8_4: got lx=%0d ly=%0d addr=%h, expected 8 4 13", lcd_x, lcd_y, video_addr);
    end
    goto(52, 29); vectors++;
    if ({lcd_x, lcd_y, video_addr} !== {6'd16, 5'd9, 8'h98}) begin
      miscompares++; $display("FAIL addr_16_9: got lx=%0d ly=%0d addr=%h, expected 16 9 98", lcd_x, lcd_y, video_addr);
    end
    goto(100, 29); vectors++;
    if ({lcd_x, video_addr} !== {6'd32, 8'h60}) begin
      miscompares++; $display("FAIL addr_32_9: got lx=%0d addr=%h, expected 32 60", lcd_x, video_addr);
    end
  endtask
  task automatic test_window;
    goto(3, 2); vectors++;
    if (lcd_active !== 1'b0) begin miscompares++; $display("FAIL win_left_out: got %b, expected 0", lcd_active); end
    goto(4, 2); vectors++;
    if ({lcd_active, lcd_x, lcd_y, video_addr} !== {1'b1, 6'd0, 5'd0, 8'h00}) begin
      miscompares++; $display("FAIL win_origin: got act=%b lx=%0d ly=%0d addr=%h, expected 1 0 0 00", lcd_active, lcd_x, lcd_y, video_addr);
    end
    goto(7, 2); vectors++;
    if ({lcd_x, video_addr} !== {6'd1, 8'h02}) begin miscompares++; $display("FAIL win_col1: got lx=%0d addr=%h, expected 1 02", lcd_x, video_addr); end
    goto(124, 2); vectors++;
    if ({lcd_active, lcd_x} !== {1'b0, 6'd0}) begin miscompares++; $display("FAIL win_right_out: got act=%b lx=%0d, expected 0 0", lcd_active, lcd_x); end
    goto(123, 49); vectors++;
    if ({lcd_active, lcd_x, lcd_y, lcd_segment_row, video_addr} !== {1'b1, 6'd39, 5'd15, 2'd3, 8'h9F}) begin
      miscompares++;
      $display("FAIL win_last: got act=%b lx=%0d ly=%0d row=%0d addr=%h, expected 1 39 15 3 9f", lcd_active, lcd_x, lcd_y, lcd_segment_row, video_addr);
    end
    goto(4, 50); vectors++;
    if ({lcd_active, lcd_y} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL win_bottom_out: got act=%b ly=%0d, expected 0 0", lcd_active, lcd_y); end
  endtask
  task automatic test_scale_latch;
    int n;
    cfg_pixel_size = 5'd2;
    goto(0, 53); vectors++;
    if (pixel_size !== 5'd3) begin miscompares++; $display("FAIL size_held_midframe: got %0d, expected 3", pixel_size); end
    wait_vsync(n); vectors++;
    if ({x, y, pixel_size} !== {10'd129, 10'd54, 5'd3}) begin
      miscompares++; $display("FAIL size_at_vsync: got x=%0d y=%0d size=%0d, expected 129 54 3", x, y, pixel_size);
    end
    @(negedge clk); vectors++;
    if (pixel_size !== 5'd2) begin miscompares++; $display("FAIL size_after_vsync: got %0d, expected 2", pixel_size); end
  endtask
  task automatic test_size2_frame;
    int n = 0, act_n = 0, grid_n = 0;
    cfg_grid_en = 1'b1; cfg_pixel_size = 5'd0;
    do begin
      @(negedge clk); n++;
      act_n += int'(lcd_active); grid_n += int'(lcd_grid);
      if (x == 10'd23 && y == 10'd10) begin vectors++;
        if (lcd_active !== 1'b0) begin miscompares++; $display("FAIL s2_left_out: got %b, expected 0", lcd_active); end
      end
      if (x == 10'd24 && y == 10'd10) begin vectors++;
        if ({lcd_active, lcd_x, lcd_y} !== {1'b1, 6'd0, 5'd0}) begin
          miscompares++; $display("FAIL s2_origin: got act=%b lx=%0d ly=%0d, expected 1 0 0", lcd_active, lcd_x, lcd_y);
        end
      end
      if (x == 10'd26 && y == 10'd10) begin vectors++;
        if (lcd_x !== 6'd1) begin miscompares++; $display("FAIL s2_col1: got %0d, expected 1", lcd_x); end
      end
      if (x == 10'd104 && y == 10'd10) begin vectors++;
        if (lcd_active !== 1'b0) begin miscompares++; $display("FAIL s2_right_out: got %b, expected 0", lcd_active); end
      end
      if (x == 10'd103 && y == 10'd41) begin vectors++;
        if ({lcd_active, lcd_x, lcd_y} !== {1'b1, 6'd39, 5'd15}) begin
          miscompares++; $display("FAIL s2_last: got act=%b lx=%0d ly=%0d, expected 1 39 15", lcd_active, lcd_x, lcd_y);
        end
      end
    end while (vsync !== 1'b1 && n < 20000);
    vectors++;
    if (act_n !== 2560) begin miscompares++; $display("FAIL s2_active_count: got %0d, expected 2560", act_n); end
    vectors++;
    if (grid_n !== 0) begin miscompares++; $display("FAIL s2_grid_count: got %0d, expected 0", grid_n); end
  endtask
  task automatic test_clamp;
    int n;
    cfg_grid_en = 1'b0;
    @(negedge clk); vectors++;
    if (pixel_size !== 5'd1) begin miscompares++; $display("FAIL clamp_zero: got %0d, expected 1", pixel_size); end
    cfg_pixel_size = 5'd31;
    goto(43, 18); vectors++;
    if (lcd_active !== 1'b0) begin miscompares++; $display("FAIL s1_left_out: got %b, expected 0", lcd_active); end
    goto(44, 18); vectors++;
    if ({lcd_active, lcd_x} !== {1'b1, 6'd0}) begin miscompares++; $display("FAIL s1_origin: got act=%b lx=%0d, expected 1 0", lcd_active, lcd_x); end
    goto(45, 18); vectors++;
    if (lcd_x !== 6'd1) begin miscompares++; $display("FAIL s1_col1: got %0d, expected 1", lcd_x); end
    wait_vsync(n);
    @(negedge clk); vectors++;
    if (pixel_size !== 5'd3) begin miscompares++; $display("FAIL clamp_max: got %0d, expected 3", pixel_size); end
  endtask
  task automatic test_reset_midframe;
    int n;
    goto(100, 30);
    reset = 1'b1;
    @(negedge clk); vectors++;
    if ({x, y, hsync, vsync, de, lcd_active} !== {10'd0, 10'd0, 4'd0}) begin
      miscompares++; $display("FAIL midreset_state: got x=%0d y=%0d hs/vs/de/act=%b, expected 0 0 0000", x, y, {hsync, vsync, de, lcd_active});
    end
    reset = 1'b0;
    wait_vsync(n); vectors++;
    if (n !== 7689 || pixel_size !== 5'd3) begin
      miscompares++; $display("FAIL midreset_vsync: got %0d cycles size=%0d, expected 7689 3", n, pixel_size);
    end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_grid();
    test_addr_map();
    test_window();
    test_scale_latch();
    test_size2_frame();
    test_clamp();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_scaled_video_gen.md
Name: lcd_scaled_video_gen

Overview:
Parametrised successor of the LCD video timing generator. Produces raster timing (x/y, hsync, vsync, de) for a configurable active area. Maps each raster position onto a centred, integer-scaled LCD segment grid and outputs the segment RAM address, segment row, grid-gap flag and LCD-active flag. Scale factor and grid mode are runtime inputs, latched once per frame. Sits between the LCD segment RAM and the video output/scaler.

Parameters:
WIDTH, 10'd360, active pixels per line
HEIGHT, 10'd360, active lines per frame
HBLANK_LEN, 10'd84, horizontal blank length in clocks
VBLANK_LEN, 10'd132, vertical blank length in lines
HSYNC_OFFSET, 10'd5, hsync position after the active line end
VSYNC_OFFSET, 10'd5, vsync line after the active frame end
LCD_COLS, 6'd32, LCD segment columns (max 40)
LCD_ROWS, 5'd16, LCD segment rows (max 16)
MAX_PIXEL_SIZE, 5'd11, largest permitted scale factor

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
cfg_pixel_size  in  5  requested scale, screen pixels per LCD pixel
cfg_grid_en  in  1  enable 1-pixel gap between LCD pixels
x  out  10  raster column
y  out  10  raster line
hsync  out  1  1-cycle line sync pulse
vsync  out  1  1-cycle frame sync pulse
de  out  1  active video
lcd_active  out  1  raster inside the scaled LCD window
lcd_grid  out  1  current pixel is a grid gap
lcd_x  out  6  LCD column index
lcd_y  out  5  LCD row index
lcd_segment_row  out  2  lcd_y[1:0]
video_addr  out  8  segment RAM address
pixel_size  out  5  scale currently in effect

Behaviour:
- Reset: x=0, y=0; hsync, vsync, de, lcd_active, lcd_grid, lcd_x, lcd_y, video_addr = 0. pixel_size loads the clamped cfg_pixel_size. Reset mid-frame restarts at (0,0) on the next cycle.
- Counters: x counts 0..WIDTH+HBLANK_LEN-1 and wraps to 0, incrementing y. y counts 0..HEIGHT+VBLANK_LEN-1 and wraps to 0.
- hsync=1 exactly when x==WIDTH+HSYNC_OFFSET.
- vsync=1 exactly when y==HEIGHT+VSYNC_OFFSET and x==WIDTH+1.
- de=1 when x<WIDTH and y<HEIGHT.
- All outputs are registered and mutually aligned: every output describes the same (x,y) in the same cycle.
- Scale latch: in the vsync cycle, pixel_size <= clamp(cfg_pixel_size). Clamp maps 0 to 1 and values above MAX_PIXEL_SIZE to MAX_PIXEL_SIZE. A change mid-frame has no effect until the next vsync.
- Window offsets, recomputed in the cycle after the latch (always inside blanking):
  - off_x = (WIDTH - LCD_COLS*pixel_size)>>1, and 0 if the product exceeds WIDTH.
  - off_y is computed the same way using HEIGHT and LCD_ROWS.
- lcd_active=1 when off_x <= x < off_x+LCD_COLS*pixel_size, y has the same relation to off_y and LCD_ROWS, and de=1. The window is clipped to the active area.
- Sub-pixel counters sx and sy each run 0..pixel_size-1.
  - sx advances when lcd_active=1. When sx wraps, lcd_x advances, wrapping to 0 after LCD_COLS-1.
  - sy advances on the last LCD pixel of each window line. When sy wraps, lcd_y advances, wrapping after LCD_ROWS-1.
  - sx, sy, lcd_x and lcd_y all reset to 0 at vsync.
  - Outside the window, lcd_x and lcd_y hold.
- lcd_grid=1 when cfg_grid_en=1, pixel_size>=3, lcd_active=1, and (sx==pixel_size-1 or sy==pixel_size-1). Otherwise lcd_grid=0.
- video_addr = {1'b0, col_map(lcd_x), lcd_y[2]}, plus 8'h50 when lcd_y>=8.
  - col_map is the fixed 40-entry panel column map: 0-7→0-7, 8-15→9-16, 16-23→36..29, 24-31→27..20, 32→8, 33-35→17-19, 36→28, 37-39→37-39.
- Arithmetic: the multiply uses 10-bit results. Counter compares use full widths, with no truncation at boundaries.

Decomposition:
- Package lcd_video_pkg holds:
  - the col_map function;
  - the bank offset constant 8'h50;
  - constants LCD_MAX_COLS=40 and LCD_MAX_ROWS=16;
  - the clamp function for the scale factor.
- One sub-module, lcd_window_scaler: offset computation, sx/sy counters and lcd_x/lcd_y stepping. The top level holds raster timing and address formation.

Test Plan:
- Reset, then run one frame with defaults and size 11 → frame length 444×492 clocks; hsync at x=365 on every line; vsync at y=365, x=361; de asserted for exactly 129600 cycles.
- Size 11 → off_x=4, off_y=92. At (4,92): lcd_active=1, lcd_x=0, lcd_y=0, video_addr=0. At (15,92): lcd_x=1. At (355,267): lcd_x=31, lcd_y=15. At (356,92): lcd_active=0.
- Address map: lcd_x=8, lcd_y=4 → video_addr=8'h13. lcd_x=16, lcd_y=9 → video_addr = {0,36,0}+0x50 = 8'h98.
- Change cfg_pixel_size from 11 to 5 mid-frame → pixel_size stays 11 until vsync, then becomes 5 with off_x=100, off_y=140. cfg_pixel_size=0 → 1; cfg_pixel_size=31 → 11.
- cfg_grid_en=1 at size 11 → lcd_grid=1 at x=14 and at line y=102 inside the window. At size 2, lcd_grid never asserts.
- Assert reset at (200,50) for one cycle → next cycle x=0, y=0, all pulses 0. Frame timing is then identical to the post-power-up frame.
